// File: rtl/adv7611_cfg_pkg.sv
// Shared definitions for the ADV7611 I2C configuration sequencer.
//   cfg_state_e      : sequencer states
//   BYTES_PER_ENTRY  : bytes written per LUT entry (dev, reg, data)
//   DEV/REG/DAT_*    : field positions inside a 24-bit LUT entry
//   quarter_div()    : system clocks per quarter SCL bit
package adv7611_cfg_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_INIT,
    ST_LOAD,
    ST_START,
    ST_SEND,
    ST_ACK,
    ST_STOP,
    ST_GAP,
    ST_DONE
  } cfg_state_e;

  localparam int unsigned BYTES_PER_ENTRY = 3;

  localparam int unsigned DEV_MSB = 23;
  localparam int unsigned DEV_LSB = 16;
  localparam int unsigned REG_MSB = 15;
  localparam int unsigned REG_LSB = 8;
  localparam int unsigned DAT_MSB = 7;
  localparam int unsigned DAT_LSB = 0;

  function automatic int unsigned quarter_div(input int unsigned clk_freq,
                                              input int unsigned i2c_freq);
    return clk_freq / (4 * i2c_freq);
  endfunction

endpackage

// File: rtl/i2c_bit_tick.sv
// Quarter-bit timebase for the I2C engine.
//   clk, rst : system clock, synchronous active-high reset
//   en_i     : count while high
//   clr_i    : synchronous clear (counter reloaded, phase back to P0)
//   tick_o   : high on the last cycle of each quarter bit
//   phase_o  : current quarter (P0..P3) of the bit
module i2c_bit_tick
  import adv7611_cfg_pkg::*;
#(
  parameter int unsigned DIV = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       clr_i,
  output logic       tick_o,
  output logic [1:0] phase_o
);

  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  phase_q, phase_d;

  assign tick_o  = en_i && (cnt_q == '0);
  assign phase_o = phase_q;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clr_i) begin
      cnt_d   = 16'(DIV - 1);
      phase_d = '0;
    end else if (en_i) begin
      if (cnt_q == '0) begin
        cnt_d   = 16'(DIV - 1);
        phase_d = phase_q + 2'd1;
      end else begin
        cnt_d = cnt_q - 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 16'(DIV - 1);
      phase_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/adv7611_i2c_cfg_ctrl.sv
// Walks the ADV7611 configuration LUT and writes each entry as a 3-byte
// I2C write (dev, reg, data), retrying NACKed entries.
//   clk, rst             : system clock, synchronous active-high reset
//   cfg_start            : restart the table from index 0 (only honoured when done)
//   lut_index / lut_data : LUT address out, {dev,reg,data} in
//   lut_size             : number of valid entries
//   i2c_scl, i2c_sda_oe  : SCL (push-pull), SDA pull-low enable
//   i2c_sda_i            : SDA pad level
//   cfg_busy, cfg_done   : sequencing status
//   ack_err, err_cnt     : sticky skip flag and saturating skip count
//
// state      | meaning
// WAIT_INIT  | power-up / restart delay of INIT_DLY cycles
// LOAD       | end-of-table check, latch current entry
// START      | START condition
// SEND       | shift 8 bits MSB first
// ACK        | release SDA, sample slave ACK at P2
// STOP       | STOP condition, retry / advance decision
// GAP        | bus idle GAP_DLY cycles between entries
// DONE       | table written, bus idle
module adv7611_i2c_cfg_ctrl
  import adv7611_cfg_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned I2C_FREQ  = 100_000,
  parameter int unsigned INIT_DLY  = 1_000_000,
  parameter int unsigned GAP_DLY   = 5_000,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_start,
  output logic [8:0]  lut_index,
  input  logic [23:0] lut_data,
  input  logic [8:0]  lut_size,
  output logic        i2c_scl,
  output logic        i2c_sda_oe,
  input  logic        i2c_sda_i,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        ack_err,
  output logic [7:0]  err_cnt
);

  localparam int unsigned Q = quarter_div(CLK_FREQ, I2C_FREQ);

  cfg_state_e  state_q;
  logic [31:0] dly_q;
  logic [23:0] shift_q;
  logic [2:0]  bit_q;
  logic [1:0]  byte_q;
  logic [7:0]  retry_q;
  logic        nack_q;
  logic [8:0]  index_q;
  logic        scl_q, sda_oe_q, busy_q, done_q, ack_err_q;
  logic [7:0]  err_cnt_q;

  logic        qtick;
  logic [1:0]  phase;
  logic        bus_active;
  logic        bit_end;

  assign bus_active = state_q inside {ST_START, ST_SEND, ST_ACK, ST_STOP};
  assign bit_end    = qtick && (phase == 2'd3);

  // Timebase is held cleared outside a frame so every frame starts at P0.
  i2c_bit_tick #(.DIV(Q)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .en_i    (bus_active),
    .clr_i   (!bus_active),
    .tick_o  (qtick),
    .phase_o (phase)
  );

  // Bus outputs are registered from the current state/phase, so they trail
  // the phase counter by one cycle uniformly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_WAIT_INIT;
      dly_q     <= '0;
      shift_q   <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      retry_q   <= '0;
      nack_q    <= 1'b0;
      index_q   <= '0;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      scl_q    <= 1'b1;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b1;
      case (state_q)
        ST_WAIT_INIT: begin
          if (dly_q == 32'(INIT_DLY - 1)) begin
            dly_q   <= '0;
            state_q <= ST_LOAD;
          end else begin
            dly_q <= dly_q + 32'd1;
          end
        end
        ST_LOAD: begin
          if (index_q >= lut_size) begin
            state_q <= ST_DONE;
          end else begin
            shift_q <= {lut_data[DEV_MSB:DEV_LSB], lut_data[REG_MSB:REG_LSB],
                        lut_data[DAT_MSB:DAT_LSB]};
            byte_q  <= '0;
            bit_q   <= 3'd7;
            nack_q  <= 1'b0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          scl_q    <= (phase != 2'd3);
          sda_oe_q <= phase[1];
          if (bit_end) state_q <= ST_SEND;
        end
        ST_SEND: begin
          scl_q    <= phase[0] ^ phase[1];
          sda_oe_q <= ~shift_q[23];
          if (bit_end) begin
            shift_q <= shift_q << 1;
            if (bit_q == 3'd0) state_q <= ST_ACK;
            else               bit_q   <= bit_q - 3'd1;
          end
        end
        ST_ACK: begin
          scl_q <= phase[0] ^ phase[1];
          if (qtick && (phase == 2'd2) && i2c_sda_i) nack_q <= 1'b1;
          if (bit_end) begin
            if (nack_q || (byte_q == 2'(BYTES_PER_ENTRY - 1))) begin
              state_q <= ST_STOP;
            end else begin
              byte_q  <= byte_q + 2'd1;
              bit_q   <= 3'd7;
              state_q <= ST_SEND;
            end
          end
        end
        ST_STOP: begin
          scl_q    <= (phase != 2'd0);
          sda_oe_q <= ~phase[1];
          if (bit_end) begin
            state_q <= ST_GAP;
            if (nack_q && (retry_q < 8'(MAX_RETRY))) begin
              retry_q <= retry_q + 8'd1;
            end else begin
              index_q <= index_q + 9'd1;
              retry_q <= '0;
              if (nack_q) begin
                ack_err_q <= 1'b1;
                if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
              end
            end
          end
        end
        ST_GAP: begin
          if (dly_q == 32'(GAP_DLY - 1)) begin
            dly_q   <= '0;
            state_q <= ST_LOAD;
          end else begin
            dly_q <= dly_q + 32'd1;
          end
        end
        ST_DONE: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          if (cfg_start) begin
            state_q <= ST_WAIT_INIT;
            index_q <= '0;
            dly_q   <= '0;
            retry_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        default: state_q <= ST_WAIT_INIT;
      endcase
    end
  end

  assign lut_index  = index_q;
  assign i2c_scl    = scl_q;
  assign i2c_sda_oe = sda_oe_q;
  assign cfg_busy   = busy_q;
  assign cfg_done   = done_q;
  assign ack_err    = ack_err_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_adv7611_i2c_cfg_ctrl.sv
// Bench for adv7611_i2c_cfg_ctrl: an I2C slave/bus monitor decodes frames and
// compares them against expected frames queued by each scenario.
module tb_adv7611_i2c_cfg_ctrl;

  localparam int unsigned CLK_FREQ  = 4_000_000;
  localparam int unsigned I2C_FREQ  = 100_000;
  localparam int unsigned INIT_DLY  = 10;
  localparam int unsigned GAP_DLY   = 20;
  localparam int unsigned MAX_RETRY = 3;
  localparam int Q          = 10;      // 4 MHz / (4 * 100 kHz)
  localparam int SCL_PERIOD = 4 * Q;

  logic        clk, rst, cfg_start;
  logic [8:0]  lut_index, lut_size;
  logic [23:0] lut_data;
  logic        i2c_scl, i2c_sda_oe, i2c_sda_i;
  logic        cfg_busy, cfg_done, ack_err;
  logic [7:0]  err_cnt;

  logic [23:0] lut_mem [0:3];
  logic        slave_low;
  logic        sda_line;

  typedef struct {
    logic [23:0] data;
    int          nbits;
  } frame_t;

  frame_t exp_q[$];
  int     errors = 0;
  int     checks = 0;
  logic [7:0] nack_dev = 8'h00;
  int     nack_left = 0;       // -1: NACK forever, 0: always ACK
  bit     ignore_frames = 0;
  int     mon_dbits = 0;
  int     per_min = 1 << 30;
  int     per_max = 0;

  assign lut_data  = lut_mem[lut_index[1:0]];
  assign sda_line  = ~(i2c_sda_oe | slave_low);
  assign i2c_sda_i = sda_line;

  adv7611_i2c_cfg_ctrl #(
    .CLK_FREQ (CLK_FREQ),
    .I2C_FREQ (I2C_FREQ),
    .INIT_DLY (INIT_DLY),
    .GAP_DLY  (GAP_DLY),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .lut_index (lut_index),
    .lut_data  (lut_data),
    .lut_size  (lut_size),
    .i2c_scl   (i2c_scl),
    .i2c_sda_oe(i2c_sda_oe),
    .i2c_sda_i (i2c_sda_i),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .ack_err   (ack_err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model and scoreboard: decodes START/bits/STOP at negedge, ACKs
  // bytes unless told to NACK a device address, checks each finished frame.
  task automatic monitor_loop();
    logic scl_p = 1'b1, sda_p = 1'b1, scl, sda;
    logic in_frame = 1'b0, pend = 1'b0, pend_bit = 1'b0;
    logic [23:0] sh = '0;
    int slots = 0, slot = 0, cyc = 0, last_rise = -1;
    frame_t e;
    slave_low = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      scl = i2c_scl;
      sda = sda_line;
      if (rst) begin
        in_frame  = 1'b0;
        pend      = 1'b0;
        slave_low = 1'b0;
      end else if (scl_p && scl && sda_p && !sda) begin
        in_frame  = 1'b1;
        sh        = '0;
        mon_dbits = 0;
        slots     = 0;
        pend      = 1'b0;
        last_rise = -1;
        slave_low = 1'b0;
      end else if (in_frame && scl_p && scl && !sda_p && sda) begin
        in_frame  = 1'b0;
        slave_low = 1'b0;
        if (!ignore_frames) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL frame_unexpected got=%h/%0d bits required=none", sh, mon_dbits);
          end else begin
            e = exp_q.pop_front();
            if (sh !== e.data || mon_dbits != e.nbits) begin
              errors++;
              $display("FAIL frame_data got=%h/%0d bits required=%h/%0d bits",
                       sh, mon_dbits, e.data, e.nbits);
            end
          end
        end
      end else if (in_frame && !scl_p && scl) begin
        pend     = 1'b1;
        pend_bit = sda;
        if (last_rise >= 0) begin
          if (cyc - last_rise < per_min) per_min = cyc - last_rise;
          if (cyc - last_rise > per_max) per_max = cyc - last_rise;
        end
        last_rise = cyc;
      end else if (in_frame && scl_p && !scl && pend) begin
        pend = 1'b0;
        slot = slots % 9;
        if (slot < 8) begin
          sh = {sh[22:0], pend_bit};
          mon_dbits++;
          if (slot == 7) begin
            if (slots / 9 == 0 && sh[7:0] == nack_dev && nack_left != 0) begin
              slave_low = 1'b0;
              if (nack_left > 0) nack_left--;
            end else begin
              slave_low = 1'b1;
            end
          end
        end else begin
          slave_low = 1'b0;
        end
        slots++;
      end
      scl_p = scl;
      sda_p = sda;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (cfg_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 7;
    if (lut_index !== 9'd0) begin errors++; $display("FAIL rst_index got=%0d required=0", lut_index); end
    if (i2c_scl !== 1'b1) begin errors++; $display("FAIL rst_scl got=%b required=1", i2c_scl); end
    if (i2c_sda_oe !== 1'b0) begin errors++; $display("FAIL rst_sda_oe got=%b required=0", i2c_sda_oe); end
    if (cfg_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b required=0", cfg_busy); end
    if (cfg_done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b required=0", cfg_done); end
    if (ack_err !== 1'b0) begin errors++; $display("FAIL rst_ack_err got=%b required=0", ack_err); end
    if (err_cnt !== 8'd0) begin errors++; $display("FAIL rst_err_cnt got=%0d required=0", err_cnt); end
  endtask

  task automatic test_size0();
    int done_at = -1, toggles = 0;
    logic scl_prev;
    lut_size = 9'd0;
    apply_reset();
    scl_prev = i2c_scl;
    for (int n = 1; n <= int'(INIT_DLY) + 10; n++) begin
      @(negedge clk);
      if (i2c_scl !== scl_prev) toggles++;
      scl_prev = i2c_scl;
      if (cfg_done === 1'b1 && done_at < 0) done_at = n;
    end
    checks += 4;
    if (done_at != int'(INIT_DLY) + 2) begin errors++; $display("FAIL size0_done_cycle got=%0d required=%0d", done_at, INIT_DLY + 2); end
    if (toggles != 0) begin errors++; $display("FAIL size0_scl_toggles got=%0d required=0", toggles); end
    if (cfg_busy !== 1'b0) begin errors++; $display("FAIL size0_busy got=%b required=0", cfg_busy); end
    if (lut_index !== 9'd0) begin errors++; $display("FAIL size0_index got=%0d required=0", lut_index); end
  endtask

  task automatic test_basic();
    bit ok;
    lut_size = 9'd2;
    nack_left = 0;
    exp_q.delete();
    exp_q.push_back('{24'h98F480, 24});
    exp_q.push_back('{24'h680000, 24});
    apply_reset();
    per_min = 1 << 30;
    per_max = 0;
    wait_done(5000, ok);
    checks += 9;
    if (!ok) begin errors++; $display("FAIL basic_timeout got=done_low required=done_high"); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL basic_frames_left got=%0d required=0", exp_q.size()); end
    if (lut_index !== 9'd2) begin errors++; $display("FAIL basic_index got=%0d required=2", lut_index); end
    if (ack_err !== 1'b0) begin errors++; $display("FAIL basic_ack_err got=%b required=0", ack_err); end
    if (err_cnt !== 8'd0) begin errors++; $display("FAIL basic_err_cnt got=%0d required=0", err_cnt); end
    if (cfg_busy !== 1'b0) begin errors++; $display("FAIL basic_busy got=%b required=0", cfg_busy); end
    if (i2c_scl !== 1'b1 || i2c_sda_oe !== 1'b0) begin errors++; $display("FAIL basic_bus_idle got=%b%b required=10", i2c_scl, i2c_sda_oe); end
    if (per_min != SCL_PERIOD) begin errors++; $display("FAIL basic_scl_period_min got=%0d required=%0d", per_min, SCL_PERIOD); end
    if (per_max != SCL_PERIOD) begin errors++; $display("FAIL basic_scl_period_max got=%0d required=%0d", per_max, SCL_PERIOD); end
  endtask

  task automatic test_nack_always();
    bit ok;
    lut_size = 9'd2;
    nack_dev = 8'h98;
    nack_left = -1;
    exp_q.delete();
    for (int i = 0; i <= int'(MAX_RETRY); i++) exp_q.push_back('{24'h000098, 8});
    exp_q.push_back('{24'h680000, 24});
    apply_reset();
    wait_done(8000, ok);
    nack_left = 0;
    checks += 5;
    if (!ok) begin errors++; $display("FAIL nack_always_timeout got=done_low required=done_high"); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL nack_always_frames_left got=%0d required=0", exp_q.size()); end
    if (ack_err !== 1'b1) begin errors++; $display("FAIL nack_always_ack_err got=%b required=1", ack_err); end
    if (err_cnt !== 8'd1) begin errors++; $display("FAIL nack_always_err_cnt got=%0d required=1", err_cnt); end
    if (lut_index !== 9'd2) begin errors++; $display("FAIL nack_always_index got=%0d required=2", lut_index); end
  endtask

  task automatic test_nack_once();
    bit ok;
    lut_size = 9'd2;
    nack_dev = 8'h98;
    nack_left = 1;
    exp_q.delete();
    exp_q.push_back('{24'h000098, 8});
    exp_q.push_back('{24'h98F480, 24});
    exp_q.push_back('{24'h680000, 24});
    apply_reset();
    wait_done(8000, ok);
    nack_left = 0;
    checks += 5;
    if (!ok) begin errors++; $display("FAIL nack_once_timeout got=done_low required=done_high"); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL nack_once_frames_left got=%0d required=0", exp_q.size()); end
    if (ack_err !== 1'b0) begin errors++; $display("FAIL nack_once_ack_err got=%b required=0", ack_err); end
    if (err_cnt !== 8'd0) begin errors++; $display("FAIL nack_once_err_cnt got=%0d required=0", err_cnt); end
    if (lut_index !== 9'd2) begin errors++; $display("FAIL nack_once_index got=%0d required=2", lut_index); end
  endtask

  task automatic test_reset_mid();
    bit ok, hit = 0;
    int oe_at = -1;
    lut_size = 9'd2;
    exp_q.delete();
    ignore_frames = 1;
    apply_reset();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (mon_dbits == 1 && i2c_scl === 1'b1) begin hit = 1; break; end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 4;
    if (!hit) begin errors++; $display("FAIL midrst_reach_bit2 got=not_reached required=reached"); end
    if (i2c_scl !== 1'b1) begin errors++; $display("FAIL midrst_scl got=%b required=1", i2c_scl); end
    if (i2c_sda_oe !== 1'b0) begin errors++; $display("FAIL midrst_sda_oe got=%b required=0", i2c_sda_oe); end
    if (lut_index !== 9'd0) begin errors++; $display("FAIL midrst_index got=%0d required=0", lut_index); end
    exp_q.push_back('{24'h98F480, 24});
    exp_q.push_back('{24'h680000, 24});
    ignore_frames = 0;
    for (int n = 1; n <= int'(INIT_DLY) + 2 * Q + 50; n++) begin
      @(negedge clk);
      if (i2c_sda_oe === 1'b1 && oe_at < 0) oe_at = n;
    end
    wait_done(5000, ok);
    checks += 4;
    if (oe_at != int'(INIT_DLY) + 2 + 2 * Q) begin errors++; $display("FAIL midrst_restart_cycle got=%0d required=%0d", oe_at, INIT_DLY + 2 + 2 * Q); end
    if (!ok) begin errors++; $display("FAIL midrst_timeout got=done_low required=done_high"); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL midrst_frames_left got=%0d required=0", exp_q.size()); end
    if (lut_index !== 9'd2) begin errors++; $display("FAIL midrst_index_end got=%0d required=2", lut_index); end
  endtask

  task automatic test_cfg_start();
    bit ok, hit = 0;
    exp_q.delete();
    exp_q.push_back('{24'h98F480, 24});
    exp_q.push_back('{24'h680000, 24});
    @(negedge clk);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    checks += 3;
    if (cfg_done !== 1'b0) begin errors++; $display("FAIL start_done_clear got=%b required=0", cfg_done); end
    if (cfg_busy !== 1'b1) begin errors++; $display("FAIL start_busy got=%b required=1", cfg_busy); end
    if (lut_index !== 9'd0) begin errors++; $display("FAIL start_index got=%0d required=0", lut_index); end
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (lut_index === 9'd1) begin hit = 1; break; end
    end
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    @(negedge clk);
    checks += 2;
    if (!hit) begin errors++; $display("FAIL start_reach_index1 got=not_reached required=reached"); end
    if (lut_index !== 9'd1) begin errors++; $display("FAIL start_busy_ignored got=%0d required=1", lut_index); end
    wait_done(5000, ok);
    checks += 4;
    if (!ok) begin errors++; $display("FAIL start_timeout got=done_low required=done_high"); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL start_frames_left got=%0d required=0", exp_q.size()); end
    if (lut_index !== 9'd2) begin errors++; $display("FAIL start_index_end got=%0d required=2", lut_index); end
    if (cfg_done !== 1'b1) begin errors++; $display("FAIL start_done_end got=%b required=1", cfg_done); end
  endtask

  initial begin
    rst       = 1'b1;
    cfg_start = 1'b0;
    lut_size  = 9'd0;
    lut_mem[0] = 24'h98F480;
    lut_mem[1] = 24'h680000;
    lut_mem[2] = 24'h000000;
    lut_mem[3] = 24'h000000;
    fork
      monitor_loop();
      begin
        test_reset();
        test_size0();
        test_basic();
        test_nack_always();
        test_nack_once();
        test_reset_mid();
        test_cfg_start();
      end
    join_any
    disable fork;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
